// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: latches decoded operands and control, decodes ALUOp/funct to ALU control.
// Optional ID_EX_PERF_EN adds saturating bubble/stall counters.
module id_ex_pipeline_reg #(
    parameter int WIDTH = 32,
    parameter int RBITS = 5,
    parameter int CBITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc4,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RBITS-1:0] id_rs,
    input  logic [RBITS-1:0] id_rt,
    input  logic [RBITS-1:0] id_rd,
    input  logic [1:0]       id_alu_op,
    input  logic [5:0]       id_funct,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_pc4,
    output logic [WIDTH-1:0] ex_rs_data,
    output logic [WIDTH-1:0] ex_rt_data,
    output logic [WIDTH-1:0] ex_imm,
    output logic [RBITS-1:0] ex_rs,
    output logic [RBITS-1:0] ex_rt,
    output logic [RBITS-1:0] ex_rd,
    output logic [CBITS-1:0] ex_alu_ctrl,
    output logic             ex_alu_src,
    output logic             ex_reg_dst,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             ex_bad_funct
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]      bubble_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [CBITS-1:0] CTRL_ADD = CBITS'(4'b0010);
    localparam logic [CBITS-1:0] CTRL_SUB = CBITS'(4'b0110);
    localparam logic [CBITS-1:0] CTRL_AND = CBITS'(4'b0000);
    localparam logic [CBITS-1:0] CTRL_OR  = CBITS'(4'b0001);
    localparam logic [CBITS-1:0] CTRL_SLT = CBITS'(4'b0111);
    localparam logic [CBITS-1:0] CTRL_NOR = CBITS'(4'b1100);

    // Returns {unsupported_funct, ctrl}; the unsupported flag is qualified by id_valid outside.
    function automatic logic [CBITS:0] f_alu_decode(input logic [1:0] op, input logic [5:0] funct);
        logic [CBITS:0] res;
        res = {1'b0, CTRL_ADD};
        case (op)
            2'b00: res = {1'b0, CTRL_ADD};
            2'b01: res = {1'b0, CTRL_SUB};
            2'b11: res = {1'b0, CTRL_OR};
            default: begin
                case (funct)
                    6'b100000: res = {1'b0, CTRL_ADD};
                    6'b100010: res = {1'b0, CTRL_SUB};
                    6'b100100: res = {1'b0, CTRL_AND};
                    6'b100101: res = {1'b0, CTRL_OR};
                    6'b101010: res = {1'b0, CTRL_SLT};
                    6'b100111: res = {1'b0, CTRL_NOR};
                    default:   res = {1'b1, CTRL_ADD};
                endcase
            end
        endcase
        return res;
    endfunction

    logic [CBITS-1:0] w_alu_ctrl;
    logic             w_bad_funct;

    always_comb begin
        {w_bad_funct, w_alu_ctrl} = f_alu_decode(id_alu_op, id_funct);
    end

    logic             r_valid;
    logic [WIDTH-1:0] r_pc4;
    logic [WIDTH-1:0] r_rs_data;
    logic [WIDTH-1:0] r_rt_data;
    logic [WIDTH-1:0] r_imm;
    logic [RBITS-1:0] r_rs;
    logic [RBITS-1:0] r_rt;
    logic [RBITS-1:0] r_rd;
    logic [CBITS-1:0] r_alu_ctrl;
    logic             r_alu_src;
    logic             r_reg_dst;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_mem_to_reg;
    logic             r_branch;
    logic             r_bad_funct;

    // Reset and flush both produce the bubble state; stall simply skips the load.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_valid      <= 1'b0;
            r_pc4        <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_alu_ctrl   <= CTRL_ADD;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
            r_bad_funct  <= 1'b0;
        end else if (!stall) begin
            r_valid      <= id_valid;
            r_pc4        <= id_pc4;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_rd         <= id_rd;
            r_alu_ctrl   <= w_alu_ctrl;
            r_alu_src    <= id_alu_src;
            r_reg_dst    <= id_reg_dst;
            r_mem_read   <= id_mem_read;
            r_mem_to_reg <= id_mem_to_reg;
            // Invalid slots must not write state or redirect fetch.
            r_reg_write  <= id_reg_write & id_valid;
            r_mem_write  <= id_mem_write & id_valid;
            r_branch     <= id_branch & id_valid;
            r_bad_funct  <= w_bad_funct & id_valid;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_pc4        = r_pc4;
    assign ex_rs_data    = r_rs_data;
    assign ex_rt_data    = r_rt_data;
    assign ex_imm        = r_imm;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rd         = r_rd;
    assign ex_alu_ctrl   = r_alu_ctrl;
    assign ex_alu_src    = r_alu_src;
    assign ex_reg_dst    = r_reg_dst;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_branch     = r_branch;
    assign ex_bad_funct  = r_bad_funct;

`ifdef ID_EX_PERF_EN
    function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_bubble_cnt;
    logic [31:0] r_stall_cnt;

    // A stall overlapped by a flush counts only as a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else if (flush) begin
            r_bubble_cnt <= f_sat_inc(r_bubble_cnt);
        end else if (stall) begin
            r_stall_cnt  <= f_sat_inc(r_stall_cnt);
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule
